// File: rtl/count_enable_ctrl_pkg.sv
// Shared types and default parameters for the count-enable control stage
// that feeds the counter_0to15 chain.
package count_enable_ctrl_pkg;

  localparam int DEFAULT_DIV       = 50_000_000;
  localparam int DEFAULT_DB_CYCLES = 500_000;

  typedef enum logic [1:0] {
    ST_STOP = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

endpackage

// File: rtl/count_enable_ctrl_if.sv
// Button, terminal-count and status signals between the control stage
// (master) and its surroundings (slave).
interface count_enable_ctrl_if;

  logic BTN_RUN;
  logic BTN_STEP;
  logic TC_IN;
  logic CE;
  logic RUNNING;
  logic HALTED;

  modport master (
    input  BTN_RUN, BTN_STEP, TC_IN,
    output CE, RUNNING, HALTED
  );

  modport slave (
    output BTN_RUN, BTN_STEP, TC_IN,
    input  CE, RUNNING, HALTED
  );

endinterface

// File: rtl/count_enable_ctrl_btn_debounce.sv
// Push-button conditioner: two-flop synchronizer, stability counter and a
// single-cycle press pulse on an accepted 0->1 change of the debounced level.
module btn_debounce #(
  parameter int DB_CYCLES = 3
) (
  input  logic C,
  input  logic CLR,
  input  logic RAW,
  output logic LEVEL,
  output logic PRESS
);

  localparam int CW = $clog2(DB_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CYCLES - 1);

  logic          sync1;
  logic          sync2;
  logic          valid1;
  logic          valid2;
  logic          armed;
  logic [CW-1:0] cnt;
  logic          differ;
  logic          expire;

  assign differ = (sync2 != LEVEL);
  assign expire = differ && (cnt == CNT_LAST);

  // A press is only honoured once a genuine low sample has been seen after
  // reset, so a button held through reset stays silent until re-pressed.
  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      valid1 <= 1'b0;
      valid2 <= 1'b0;
      armed  <= 1'b0;
      cnt    <= '0;
      LEVEL  <= 1'b0;
    end else begin
      sync1  <= RAW;
      sync2  <= sync1;
      valid1 <= 1'b1;
      valid2 <= valid1;
      if (valid2 && !sync2) begin
        armed <= 1'b1;
      end
      if (!differ) begin
        cnt <= '0;
      end else if (expire) begin
        cnt   <= '0;
        LEVEL <= sync2;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign PRESS = expire && sync2 && armed;

endmodule

// File: rtl/count_enable_ctrl.sv
// Count-enable controller: debounced RUN/STOP and STEP buttons, RUN-mode
// prescaler and a STOP/RUN/HALT state machine producing one-cycle CE strobes.
module count_enable_ctrl
  import count_enable_ctrl_pkg::*;
#(
  parameter int DIV        = DEFAULT_DIV,
  parameter int DB_CYCLES  = DEFAULT_DB_CYCLES,
  parameter bit STOP_ON_TC = 1'b1
) (
  input  logic                C,
  input  logic                CLR,
  count_enable_ctrl_if.master bus
);

  localparam int PW = $clog2(DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);

  state_t        state_q;
  state_t        state_d;
  logic [PW-1:0] presc_q;
  logic          wrap_ok_q;
  logic          tick;
  logic          tc_halt;
  logic          run_press;
  logic          step_press;
  logic          run_level;
  logic          step_level;
  logic          ce_q;
  logic          running_q;
  logic          halted_q;
  logic          ce_d;
  logic          running_d;
  logic          halted_d;
  logic          unused_levels;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_run_btn (
    .C     (C),
    .CLR   (CLR),
    .RAW   (bus.BTN_RUN),
    .LEVEL (run_level),
    .PRESS (run_press)
  );

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step_btn (
    .C     (C),
    .CLR   (CLR),
    .RAW   (bus.BTN_STEP),
    .LEVEL (step_level),
    .PRESS (step_press)
  );

  assign unused_levels = run_level ^ step_level;

  assign tick = (state_q == ST_RUN) && (presc_q == PRESC_LAST);
  // After resuming from HALT the chain still shows TC; the first tick must wrap it.
  assign tc_halt = tick && bus.TC_IN && STOP_ON_TC && !wrap_ok_q;

  always_ff @(posedge C or posedge CLR) begin
    if (CLR) begin
      state_q   <= ST_STOP;
      presc_q   <= '0;
      wrap_ok_q <= 1'b0;
      ce_q      <= 1'b0;
      running_q <= 1'b0;
      halted_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ce_q      <= ce_d;
      running_q <= running_d;
      halted_q  <= halted_d;
      if ((state_q != ST_RUN) || (state_d != ST_RUN) || tick) begin
        presc_q <= '0;
      end else begin
        presc_q <= presc_q + 1'b1;
      end
      if ((state_q == ST_HALT) && (state_d == ST_RUN)) begin
        wrap_ok_q <= 1'b1;
      end else if (tick || (state_d != ST_RUN)) begin
        wrap_ok_q <= 1'b0;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_STOP: if (run_press) state_d = ST_RUN;
      ST_RUN: begin
        if (run_press) begin
          state_d = ST_STOP;
        end else if (tc_halt) begin
          state_d = ST_HALT;
        end
      end
      ST_HALT: if (run_press) state_d = ST_RUN;
      default: state_d = ST_STOP;
    endcase
  end

  always_comb begin
    ce_d = 1'b0;
    case (state_q)
      ST_STOP: ce_d = step_press && !run_press;
      ST_RUN:  ce_d = tick && !run_press && !tc_halt;
      default: ce_d = 1'b0;
    endcase
    running_d = (state_d == ST_RUN);
    halted_d  = (state_d == ST_HALT);
  end

  assign bus.CE      = ce_q;
  assign bus.RUNNING = running_q;
  assign bus.HALTED  = halted_q;

endmodule

// File: tb/tb_count_enable_ctrl.sv
// Directed bench for count_enable_ctrl with DIV=4, DB_CYCLES=3: one halting
// and one free-wrapping instance, each driving a behavioural 0..15 counter.
module tb_count_enable_ctrl;

  logic C;
  logic CLR;
  logic [3:0] q1;
  logic [3:0] q2;
  int checks;
  int errors;
  int ceSeen1;

  count_enable_ctrl_if bus1 ();
  count_enable_ctrl_if bus2 ();

  count_enable_ctrl #(.DIV(4), .DB_CYCLES(3), .STOP_ON_TC(1'b1)) u_dut1 (
    .C   (C),
    .CLR (CLR),
    .bus (bus1)
  );

  count_enable_ctrl #(.DIV(4), .DB_CYCLES(3), .STOP_ON_TC(1'b0)) u_dut2 (
    .C   (C),
    .CLR (CLR),
    .bus (bus2)
  );

  initial C = 1'b0;
  always #5 C = ~C;

  // Stand-ins for the downstream counter_0to15 chains.
  always @(posedge C or posedge CLR) begin
    if (CLR) q1 <= 4'd0;
    else if (bus1.CE) q1 <= q1 + 4'd1;
  end

  always @(posedge C or posedge CLR) begin
    if (CLR) q2 <= 4'd0;
    else if (bus2.CE) q2 <= q2 + 4'd1;
  end

  assign bus1.TC_IN = (q1 == 4'd15);
  assign bus2.TC_IN = (q2 == 4'd15);

  initial ceSeen1 = 0;
  always @(posedge C) if (bus1.CE) ceSeen1 = ceSeen1 + 1;

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks = checks + 1;
    if (actual !== expected) begin
      errors = errors + 1;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic run, input logic step, input int n);
    bus1.BTN_RUN  = run;
    bus1.BTN_STEP = step;
    bus2.BTN_RUN  = run;
    bus2.BTN_STEP = step;
    repeat (n) begin
      @(posedge C);
      #1;
    end
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int base;
    int bad;
    logic expCe;
    checks = 0;
    errors = 0;
    CLR = 1'b1;
    bus1.BTN_RUN = 1'b0;
    bus1.BTN_STEP = 1'b0;
    bus2.BTN_RUN = 1'b0;
    bus2.BTN_STEP = 1'b0;

    #12;
    checkOutput("reset_ce", int'(bus1.CE), 0);
    checkOutput("reset_running", int'(bus1.RUNNING), 0);
    checkOutput("reset_halted", int'(bus1.HALTED), 0);
    @(posedge C);
    #1;
    CLR = 1'b0;
    applyStimulus(0, 0, 5);

    // Two short bursts, each under the debounce window.
    base = ceSeen1;
    applyStimulus(0, 1, 2);
    applyStimulus(0, 0, 1);
    applyStimulus(0, 1, 2);
    applyStimulus(0, 0, 10);
    checkOutput("bounce_ce_count", ceSeen1 - base, 0);
    checkOutput("bounce_q", int'(q1), 0);

    // Single step: CE appears right after the fifth sampling edge.
    applyStimulus(0, 1, 4);
    checkOutput("step_ce_early", int'(bus1.CE), 0);
    applyStimulus(0, 1, 1);
    checkOutput("step_ce_edge5", int'(bus1.CE), 1);
    applyStimulus(0, 1, 1);
    checkOutput("step_ce_width", int'(bus1.CE), 0);
    checkOutput("step_q", int'(q1), 1);
    base = ceSeen1;
    applyStimulus(0, 1, 10);
    checkOutput("step_held_ce_count", ceSeen1 - base, 0);
    applyStimulus(0, 0, 8);

    // Button held across reset must not step until re-pressed.
    bus1.BTN_STEP = 1'b1;
    bus2.BTN_STEP = 1'b1;
    CLR = 1'b1;
    applyStimulus(0, 1, 2);
    CLR = 1'b0;
    base = ceSeen1;
    applyStimulus(0, 1, 12);
    checkOutput("held_thru_reset_ce", ceSeen1 - base, 0);
    applyStimulus(0, 0, 8);
    base = ceSeen1;
    applyStimulus(0, 1, 8);
    applyStimulus(0, 0, 4);
    checkOutput("repress_ce_count", ceSeen1 - base, 1);

    CLR = 1'b1;
    applyStimulus(0, 0, 2);
    CLR = 1'b0;
    applyStimulus(0, 0, 3);
    checkOutput("run_q_start", int'(q1), 0);

    // RUN mode: 15 ticks to reach 15, the 16th halts (instance 2 wraps instead).
    applyStimulus(1, 0, 4);
    checkOutput("run_running_early", int'(bus1.RUNNING), 0);
    applyStimulus(1, 0, 1);
    checkOutput("run_running_rise", int'(bus1.RUNNING), 1);
    bad = 0;
    for (int k = 1; k <= 64; k++) begin
      applyStimulus(0, 0, 1);
      expCe = ((k % 4) == 0) && (k < 64);
      if (bus1.CE !== expCe) bad = bad + 1;
    end
    checkOutput("run_ce_pattern", bad, 0);
    checkOutput("halt_halted", int'(bus1.HALTED), 1);
    checkOutput("halt_running", int'(bus1.RUNNING), 0);
    checkOutput("halt_q", int'(q1), 15);
    checkOutput("wrap_ce", int'(bus2.CE), 1);
    checkOutput("wrap_halted", int'(bus2.HALTED), 0);
    applyStimulus(0, 0, 1);
    checkOutput("wrap_q", int'(q2), 0);
    checkOutput("wrap_running", int'(bus2.RUNNING), 1);
    applyStimulus(0, 0, 6);
    checkOutput("halt_q_hold", int'(q1), 15);
    checkOutput("halt_hold", int'(bus1.HALTED), 1);

    // Resume from HALT: first CE wraps the chain to 0.
    applyStimulus(1, 0, 4);
    checkOutput("resume_early", int'(bus1.RUNNING), 0);
    applyStimulus(1, 0, 1);
    checkOutput("resume_running", int'(bus1.RUNNING), 1);
    checkOutput("resume_halted", int'(bus1.HALTED), 0);
    applyStimulus(0, 0, 3);
    checkOutput("resume_ce_early", int'(bus1.CE), 0);

    // Next press lands on the same edge as the second tick after resume.
    applyStimulus(1, 0, 1);
    checkOutput("resume_ce", int'(bus1.CE), 1);
    applyStimulus(1, 0, 1);
    checkOutput("resume_wrap_q", int'(q1), 0);
    applyStimulus(1, 0, 2);
    checkOutput("race_presc_last", int'(u_dut1.presc_q), 3);
    applyStimulus(1, 0, 1);
    checkOutput("race_running", int'(bus1.RUNNING), 0);
    checkOutput("race_ce", int'(bus1.CE), 0);
    checkOutput("race_presc", int'(u_dut1.presc_q), 0);
    applyStimulus(0, 0, 1);
    checkOutput("race_q", int'(q1), 0);
    applyStimulus(0, 0, 8);

    // Asynchronous clear while a CE strobe is on the output.
    applyStimulus(1, 0, 5);
    checkOutput("preclr_running", int'(bus1.RUNNING), 1);
    applyStimulus(0, 0, 4);
    checkOutput("preclr_ce", int'(bus1.CE), 1);
    #3;
    CLR = 1'b1;
    #1;
    checkOutput("clr_ce", int'(bus1.CE), 0);
    checkOutput("clr_running", int'(bus1.RUNNING), 0);
    checkOutput("clr_halted", int'(bus1.HALTED), 0);
    checkOutput("clr_q", int'(q1), 0);
    applyStimulus(0, 0, 2);
    CLR = 1'b0;
    applyStimulus(0, 0, 2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
